pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake and a one-entry skid buffer, replacing the fixed-width, always-loading inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a control bundle and a data bundle, and supports backpressure, flush (control-hazard squash) and bubble insertion. It also keeps a saturating stall counter for performance monitoring. One instance is placed between each pair of pipeline stages.

## Interface
Parameters:
- CTRL_W, 21: width of the control-signal bundle.
- DATA_W, 32: width of the data bundle (instruction, PC, operands, etc. concatenated by the instantiating stage).
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept an entry.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  stage presents an entry downstream.
- out_ready  in  1  downstream accepts the entry.
- out_ctrl  out  CTRL_W  control bundle; all zeros whenever out_valid=0 (bubble = NOP).
- out_data  out  DATA_W  data bundle of the head entry.
- occupancy  out  2  number of held entries (0, 1 or 2).
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- Storage: main register (M) drives the outputs; skid register (S) holds one overflow entry.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- State machine, registered state, encoded as occupancy:
  - EMPTY (0): accept -> ONE, M <= input.
  - ONE (1): accept & drain -> ONE, M <= input; accept & !drain -> TWO, S <= input; !accept & drain -> EMPTY; otherwise hold.
  - TWO (2): inputs ignored. Drain -> ONE, M <= S. Otherwise hold.
- in_ready = (state != TWO). It is decoded from the registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_data = M data. out_ctrl = M ctrl when valid, else zero.
- Flush has the highest priority over accept and drain. The next state is EMPTY, and M and S (ctrl and data) are cleared to zero. An entry accepted in the flush cycle is discarded. A drain in the flush cycle still counts as transferred downstream, because the downstream stage samples on the same edge.
- Entries leave in arrival order; the block never reorders or duplicates them.
- stall_cnt increments by 1 on every cycle with out_valid=1 & out_ready=0, and saturates at 2^CNT_W-1. Only reset clears it; flush does not.
- Reset (asynchronous, immediate):
  - State is EMPTY.
  - M and S are all zeros.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
  - in_ready=1.
  - Transfers during reset are discarded. Reset asserted mid-operation drops all held entries.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N (one cycle).
- Throughput: one entry per cycle when out_ready is held high. No bubble is inserted in steady state.
- Backpressure: after out_ready drops, at most one more entry is accepted (into S). in_ready falls in the cycle after that accept.
- Recovery: out_ready rising in TWO drains M. S moves to M at that edge, and in_ready rises in the following cycle.
- Flush: out_valid=0 and occupancy=0 in the cycle after the flush edge. in_ready=1 in that cycle.
- Reset deassertion: the first accept is possible on the first rising edge after reset falls.

## Test plan
- Streaming: out_ready=1; send data 0x100..0x104 with ctrl 0x1 on consecutive cycles -> each value appears on out_data exactly one cycle later; occupancy stays 1; stall_cnt=0.
- Backpressure: hold out_ready=0 and send A=0xAA, B=0xBB, C=0xCC -> out_data=0xAA; occupancy reaches 2; in_ready=0 and C is not accepted; stall_cnt increments each stalled cycle. Raise out_ready -> A, B, C are delivered in order with no loss.
- Flush: with two entries held, pulse flush together with in_valid (data 0xDD) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xDD never appears.
- Bubble: after in_valid falls and the last entry drains -> out_valid=0 and out_ctrl=0 while out_data holds its previous value.
- Reset: assert reset asynchronously (between edges) while occupancy=2 and stall_cnt=5 -> all outputs go to zero immediately, in_ready=1; after deassertion the first input is passed normally.
- Saturation: CNT_W=4; hold a stall for 20 cycles -> stall_cnt=15 and stays at 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid
// buffer. M drives the outputs and S catches the one entry that can arrive
// after downstream stalls. in_ready is decoded from registered state only.
// Also keeps a saturating stall counter for performance monitoring.
module pipe_stage_skid #(
  parameter int CTRL_W = 21,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept, drain;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = out_valid ? m_ctrl_q : '0;
  assign out_data  = m_data_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Next-state logic: flush dominates, otherwise step the 0/1/2 occupancy FSM.
  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (flush) begin
      // Any drain this cycle has already been sampled downstream.
      state_d  = EMPTY;
      m_ctrl_d = '0;
      m_data_d = '0;
      s_ctrl_d = '0;
      s_data_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = ONE;
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end else if (accept) begin
            state_d  = TWO;
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
          end else if (drain) begin
            // M keeps its data so out_data holds through the bubble.
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d  = ONE;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Saturating stall counter: head entry presented but not taken.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  // State and storage registers; reset drops everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios followed by random traffic,
// checked against a queue-based model of a 2-deep in-order FIFO stage.
module tb_pipe_stage_skid;
  localparam int CTRL_W = 21;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            sb[$];       // entries accepted and not yet delivered
  logic [DATA_W-1:0] last_data;   // data of the most recent head, shown during bubbles
  int                exp_stall;
  int                n_vec = 0;
  int                n_err = 0;
  logic              dd_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: at mid-cycle, compare DUT outputs with the model, then advance
  // the model by what the coming rising edge will do.
  initial begin
    last_data = '0;
    exp_stall = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        last_data = '0;
        exp_stall = 0;
      end else begin
        logic   v_exp, drn, acc;
        entry_t hd;
        v_exp = (sb.size() > 0);
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        chk("in_ready",  64'(in_ready),  64'(sb.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(v_exp));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        if (v_exp) begin
          hd = sb[0];
          chk("out_ctrl", 64'(out_ctrl), 64'(hd.ctrl));
          chk("out_data", 64'(out_data), 64'(hd.data));
        end else begin
          chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
          chk("bubble_data", 64'(out_data), 64'(last_data));
        end
        if (out_valid && out_data == 32'hDD) dd_seen = 1'b1;
        drn = v_exp && out_ready;
        acc = in_valid && (sb.size() < 2);
        if (v_exp && !out_ready && exp_stall < (1 << CNT_W) - 1) exp_stall++;
        if (drn) begin
          hd = sb.pop_front();
          last_data = hd.data;
        end
        if (flush) begin
          sb.delete();
          last_data = '0;
        end else if (acc) begin
          sb.push_back('{ctrl: in_ctrl, data: in_data});
        end
      end
    end
  end

  // One cycle of stimulus: inputs change 2 time units after the rising edge.
  task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset_check();
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_ctrl",  64'(out_ctrl),  64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Streaming with downstream always ready.
    for (int i = 0; i < 5; i++) step(1'b1, 21'h1, 32'h100 + i, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: C is held off until the stage drains.
    step(1'b1, 21'h2, 32'hAA, 1'b0, 1'b0);
    step(1'b1, 21'h3, 32'hBB, 1'b0, 1'b0);
    step(1'b1, 21'h4, 32'hCC, 1'b0, 1'b0);
    step(1'b1, 21'h4, 32'hCC, 1'b0, 1'b0);
    step(1'b1, 21'h4, 32'hCC, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with two held entries and a simultaneous input.
    step(1'b1, 21'h5, 32'h11, 1'b0, 1'b0);
    step(1'b1, 21'h6, 32'h22, 1'b0, 1'b0);
    step(1'b1, 21'h7, 32'hDD, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset while full and stalled, then normal pass-through.
    step(1'b1, 21'h8, 32'h33, 1'b0, 1'b0);
    step(1'b1, 21'h9, 32'h44, 1'b0, 1'b0);
    guard = 0;
    while (stall_cnt < 5 && guard < 20) begin
      step(1'b0, '0, '0, 1'b0, 1'b0);
      guard++;
    end
    chk("stall_reached_5", 64'(stall_cnt >= 5), 64'(1));
    async_reset_check();
    step(1'b1, 21'hA, 32'h55, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Saturation of the 4-bit stall counter.
    step(1'b1, 21'hB, 32'h66, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("stall_saturated", 64'(stall_cnt), 64'(15));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    async_reset_check();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset_check();
      step($urandom_range(0, 9) < 7, CTRL_W'($urandom), $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    chk("dd_never_delivered", 64'(dd_seen), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
